// File: rtl/note_divider_seq.sv
// Iterative restoring divider: splits a note index into octave (quotient) and
// note-within-octave (remainder), one quotient bit per clock, MSB first.
module note_divider_seq #(
    parameter int NUM_W = 8,
    parameter int DEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NUM_W-1:0] numerator,
    input  logic [DEN_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] quotient,
    output logic [DEN_W-1:0] remainder,
    output logic             div_zero
);

    localparam int CNT_W = (NUM_W > 1) ? $clog2(NUM_W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic               accept;
    logic [NUM_W-1:0]   dvd;
    logic [DEN_W:0]     prem;
    logic [DEN_W-1:0]   dsr;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_W-1:0]   dvd_step;
    logic [DEN_W:0]     prem_step;

    // One restoring step: returns {next partial remainder, next dividend/quotient shift}.
    // The dividend register doubles as the quotient register as bits shift out.
    function automatic logic [NUM_W+DEN_W:0] restore_step(
        input logic [DEN_W:0]   pr,
        input logic [NUM_W-1:0] dv,
        input logic [DEN_W-1:0] d
    );
        logic [DEN_W:0] shifted;
        shifted = (pr << 1) | {{DEN_W{1'b0}}, dv[NUM_W-1]};
        if (shifted >= {1'b0, d})
            restore_step = {shifted - {1'b0, d}, dv[NUM_W-2:0], 1'b1};
        else
            restore_step = {shifted, dv[NUM_W-2:0], 1'b0};
    endfunction

    assign {prem_step, dvd_step} = restore_step(prem, dvd, dsr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = (divisor == '0) ? DONE : RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == '0)
                    state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd       <= '0;
            prem      <= '0;
            dsr       <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else if (accept) begin
            if (divisor != '0) begin
                dvd  <= numerator;
                dsr  <= divisor;
                prem <= '0;
                cnt  <= CNT_W'(NUM_W - 1);
            end else begin
                quotient  <= '1;
                remainder <= '0;
                div_zero  <= 1'b1;
            end
        end else if (state == RUN) begin
            dvd  <= dvd_step;
            prem <= prem_step;
            cnt  <= cnt - 1'b1;
            if (cnt == '0) begin
                quotient  <= dvd_step;
                remainder <= prem_step[DEN_W-1:0];
                div_zero  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_note_divider_seq.sv
// Bench for note_divider_seq: directed scenarios, full operand sweep and
// randomized operations checked against plain integer division.
module tb_note_divider_seq;

    localparam int NUM_W = 8;
    localparam int DEN_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [NUM_W-1:0] numerator;
    logic [DEN_W-1:0] divisor;
    logic             busy;
    logic             done;
    logic [NUM_W-1:0] quotient;
    logic [DEN_W-1:0] remainder;
    logic             div_zero;

    int n_assert = 0;
    int n_fail   = 0;
    int last_q   = 0;
    int last_r   = 0;

    note_divider_seq #(.NUM_W(NUM_W), .DEN_W(DEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .numerator (numerator),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: octave/note split by ordinary integer division.
    task automatic model(input int n, input int d, output int q, output int r, output int dz);
        if (d == 0) begin
            q = (1 << NUM_W) - 1; r = 0; dz = 1;
        end else begin
            q = n / d; r = n % d; dz = 0;
        end
    endtask

    // Called at #1 after an edge; issues start and follows the operation to its done cycle.
    task automatic run_op(input int n, input int d, input bit scramble, input bit glitch);
        int eq, er, edz, lat, bcnt;
        model(n, d, eq, er, edz);
        numerator = NUM_W'(n);
        divisor   = DEN_W'(d);
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 1;
        bcnt  = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bcnt++;
            chk("hold_quotient", 32'(quotient), 32'(last_q));
            chk("hold_remainder", 32'(remainder), 32'(last_r));
            if (scramble) begin
                numerator = NUM_W'($urandom);
                divisor   = DEN_W'($urandom);
            end
            if (glitch && lat == 3) begin
                start = 1'b1; numerator = 8'd99; divisor = 4'd5;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'((d == 0) ? 1 : NUM_W + 1));
        chk("busy_cycles", 32'(bcnt), 32'((d == 0) ? 0 : NUM_W));
        chk("quotient", 32'(quotient), 32'(eq));
        chk("remainder", 32'(remainder), 32'(er));
        chk("div_zero", 32'(div_zero), 32'(edz));
        chk("busy_in_done", 32'(busy), 32'd0);
        last_q = eq;
        last_r = er;
    endtask

    task automatic idle_check(input int k);
        start = 1'b0;
        repeat (k) begin
            @(posedge clk); #1;
            chk("idle_done", 32'(done), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_quotient", 32'(quotient), 32'(last_q));
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; numerator = '0; divisor = '0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_remainder", 32'(remainder), 32'd0);
        chk("rst_div_zero", 32'(div_zero), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(20, 12, 1'b0, 1'b0);
        idle_check(2);
        run_op(255, 12, 1'b0, 1'b0);
        run_op(63, 7, 1'b0, 1'b0);
        idle_check(1);
        run_op(37, 0, 1'b0, 1'b0);
        run_op(12, 12, 1'b0, 1'b0);
        idle_check(1);

        // start pulsed mid-run is ignored; start during done is accepted back-to-back
        run_op(20, 12, 1'b0, 1'b1);
        run_op(30, 12, 1'b0, 1'b0);
        idle_check(2);

        // asynchronous reset in the middle of a run
        numerator = 8'd20; divisor = 4'd12; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_quotient", 32'(quotient), 32'd0);
        chk("midrst_remainder", 32'(remainder), 32'd0);
        chk("midrst_div_zero", 32'(div_zero), 32'd0);
        last_q = 0; last_r = 0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("inrst_done", 32'(done), 32'd0);
        end
        @(negedge clk); rst_n = 1'b1;
        idle_check(2);
        run_op(20, 12, 1'b0, 1'b0);
        idle_check(1);

        // operands scrambled every cycle after acceptance
        run_op(200, 9, 1'b1, 1'b0);
        run_op(77, 3, 1'b1, 1'b0);

        for (int n = 0; n < (1 << NUM_W); n++)
            for (int d = 1; d < (1 << DEN_W); d++)
                run_op(n, d, 1'b0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            run_op(int'($urandom_range((1 << NUM_W) - 1, 0)),
                   int'($urandom_range((1 << DEN_W) - 1, 0)), 1'b1, 1'b0);
            if ($urandom_range(3, 0) == 0) idle_check(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
